// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: accepts an N-bit word on a valid/ready
// handshake and streams it LSB- or MSB-first with per-beat backpressure.
module serial_word_tx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_dir,
  output logic         s_out,
  output logic         s_valid,
  output logic         s_last,
  input  logic         s_ready,
  output logic         busy,
  output logic         done
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          dir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sr    <= in_data;
          dir   <= in_dir;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: if (s_ready) begin
          sr <= dir ? {sr[N-2:0], 1'b0} : {1'b0, sr[N-1:1]};
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state; s_ready/in_valid never reach them.
  assign in_ready = (state == IDLE);
  assign s_valid  = (state == SHIFT);
  assign s_out    = s_valid & (dir ? sr[N-1] : sr[0]);
  assign s_last   = s_valid & (cnt == LAST);
  assign busy     = (state == SHIFT) | (state == DONE);
  assign done     = (state == DONE);
endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: directed scenarios plus random words with random
// backpressure, checked against a per-beat bit model of the word.
module tb_serial_word_tx;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, in_dir;
  logic [N-1:0] in_data;
  logic         s_out, s_valid, s_last, s_ready, busy, done;

  int total = 0;
  int bad   = 0;

  serial_word_tx #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dir(in_dir),
    .s_out(s_out), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_s_valid"},  s_valid,  0);
    chk({tag, "_s_out"},    s_out,    0);
    chk({tag, "_s_last"},   s_last,   0);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_done"},     done,     0);
  endtask

  function automatic logic beat_bit(input logic [N-1:0] d, input logic dr, input int i);
    return dr ? d[N-1-i] : d[i];
  endfunction

  // Send one word; beat stall_beat is held off for stall_n cycles, other beats
  // get a random stall of up to max_rand cycles.
  task automatic send(input logic [N-1:0] d, input logic dr,
                      input int stall_beat, input int stall_n, input int max_rand);
    int st;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_dir = dr;
    @(negedge clk);
    in_valid = 1'b0; in_data = N'($urandom); in_dir = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      st = (i == stall_beat) ? stall_n : ((max_rand > 0) ? int'($urandom_range(max_rand, 0)) : 0);
      for (int k = 0; k <= st; k++) begin
        chk("beat_s_valid", s_valid, 1);
        chk("beat_s_out", s_out, beat_bit(d, dr, i));
        chk("beat_s_last", s_last, (i == N-1));
        chk("beat_busy", busy, 1);
        chk("beat_in_ready", in_ready, 0);
        chk("beat_done", done, 0);
        s_ready = (k == st);
        @(negedge clk);
      end
    end
    chk("done_pulse", done, 1);
    chk("done_s_valid", s_valid, 0);
    chk("done_s_out", s_out, 0);
    chk("done_busy", busy, 1);
    chk("done_in_ready", in_ready, 0);
    s_ready = 1'($urandom);
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    logic [N-1:0] wa, wb;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; s_ready = 1'b0;
    #1 chk_reset_outs("rst_init");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    send(4'b1011, 1'b0, -1, 0, 0);
    send(4'b1011, 1'b1, -1, 0, 0);
    send(4'b0110, 1'b0, 1, 3, 0);

    // back-to-back with in_valid held high through the whole first word
    wa = 4'hA; wb = 4'h5;
    @(negedge clk);
    in_valid = 1'b1; in_data = wa; in_dir = 1'b0; s_ready = 1'b1;
    @(negedge clk);
    in_data = wb;
    for (int c = 0; c < N + 2; c++) begin
      if (c < N) begin
        chk("b2b_a_s_valid", s_valid, 1);
        chk("b2b_a_s_out", s_out, wa[c]);
        chk("b2b_a_in_ready", in_ready, 0);
      end else if (c == N) begin
        chk("b2b_a_done", done, 1);
        chk("b2b_a_done_in_ready", in_ready, 0);
      end else begin
        chk("b2b_idle_in_ready", in_ready, 1);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("b2b_b_s_valid", s_valid, 1);
      chk("b2b_b_s_out", s_out, wb[i]);
      @(negedge clk);
    end
    chk("b2b_b_done", done, 1);
    @(negedge clk);
    chk("b2b_b_idle", in_ready, 1);

    // reset in the middle of a word
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'hF; in_dir = 1'b0; s_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1 chk_reset_outs("rst_mid");
    #3 reset_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst_after1");
    @(negedge clk);
    chk("rst_after2_done", done, 0);
    send(4'b1001, 1'b0, -1, 0, 0);

    for (int w = 0; w < 25; w++)
      send(N'($urandom), 1'($urandom), -1, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
